// File: rtl/cla_pkg.sv
// cla_pkg: shared carry-lookahead constants, types and 4-input lookahead functions.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

    function automatic int num_groups(input int width);
        return (width + CLA_GROUP_W - 1) / CLA_GROUP_W;
    endfunction

    function automatic logic grp_p(input logic [3:0] p);
        return &p;
    endfunction

    function automatic logic grp_g(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Carry into each of the four positions; bit 0 is the incoming carry itself.
    function automatic logic [3:0] grp_c(input logic [3:0] p, input logic [3:0] g, input logic ci);
        return {g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci),
                g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci),
                g[0] | (p[0] & ci),
                ci};
    endfunction

    // Carry into group k of up to 16 groups, via a lookahead over groups of four groups.
    function automatic logic grp_cin(input logic [15:0] pg, input logic [15:0] gg,
                                     input logic ci, input int k);
        logic [3:0] sp, sg, sc, c;
        for (int j = 0; j < 4; j++) begin
            sp[j] = grp_p(pg[4*j +: 4]);
            sg[j] = grp_g(pg[4*j +: 4], gg[4*j +: 4]);
        end
        sc = grp_c(sp, sg, ci);
        c  = grp_c(pg[4*(k/4) +: 4], gg[4*(k/4) +: 4], sc[k/4]);
        return c[k%4];
    endfunction

endpackage

// File: rtl/cla_group4.sv
// cla_group4: 4-bit combinational lookahead group producing in-group carries and group P/G.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       ci_i,
    output logic [3:0] carries_o,
    output logic       gp_o,
    output logic       gg_o
);

    assign carries_o = grp_c(p_i, g_i, ci_i);
    assign gp_o      = grp_p(p_i);
    assign gg_o      = grp_g(p_i, g_i);

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: two-stage elastic carry-lookahead adder/subtractor with flags.
// Define CLA_SATURATE_EN to add the sat input that clamps the sum on signed overflow.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
`ifdef CLA_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NG = num_groups(WIDTH);

    if (GROUP_W != CLA_GROUP_W || WIDTH % CLA_GROUP_W != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_cfg
        $error("pipelined_cla_adder: unsupported WIDTH/GROUP_W combination");
    end

    logic [WIDTH-1:0] b_eff, p_d, g_d, p_q, g_q;
    logic             cin_d, cin_q, v1_q, v2_q, s2_load;
    cla_pg_t [NG-1:0] grp_d, grp_q;
    logic [WIDTH-1:0] c_all, raw, sum_d, sum_q;
    logic [NG-1:0]    gc, gp2, gg2;
    logic [15:0]      gp16, gg16;
    logic             cout_d, ovf_d, zero_d, cout_q, ovf_q, zero_q;
`ifdef CLA_SATURATE_EN
    logic             sat_q, amsb_q;
`endif

    assign b_eff = sub ? ~b : b;
    assign cin_d = sub | c_in;
    assign p_d   = a ^ b_eff;
    assign g_d   = a & b_eff;

    for (genvar k = 0; k < NG; k++) begin : g_s1
        assign grp_d[k].p = grp_p(p_d[4*k +: 4]);
        assign grp_d[k].g = grp_g(p_d[4*k +: 4], g_d[4*k +: 4]);
    end

    assign s2_load   = ~v2_q | out_ready;
    assign in_ready  = ~v1_q | s2_load;
    assign out_valid = v2_q;

    always_comb begin
        gp16 = '0;
        gg16 = '0;
        for (int k = 0; k < NG; k++) begin
            gp16[k] = grp_q[k].p;
            gg16[k] = grp_q[k].g;
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_s2
        assign gc[k] = grp_cin(gp16, gg16, cin_q, k);
        cla_group4 u_grp (
            .p_i      (p_q[4*k +: 4]),
            .g_i      (g_q[4*k +: 4]),
            .ci_i     (gc[k]),
            .carries_o(c_all[4*k +: 4]),
            .gp_o     (gp2[k]),
            .gg_o     (gg2[k])
        );
    end

    assign raw    = p_q ^ c_all;
    assign cout_d = gg2[NG-1] | (gp2[NG-1] & gc[NG-1]);
    assign ovf_d  = c_all[WIDTH-1] ^ cout_d;
`ifdef CLA_SATURATE_EN
    // On overflow the operands share a sign, so a's MSB tells which rail to clamp to.
    assign sum_d  = (sat_q && ovf_d) ? {amsb_q, {(WIDTH-1){~amsb_q}}} : raw;
`else
    assign sum_d  = raw;
`endif
    assign zero_d = ~|sum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p_q    <= '0;
            g_q    <= '0;
            cin_q  <= 1'b0;
            grp_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
`ifdef CLA_SATURATE_EN
            sat_q  <= 1'b0;
            amsb_q <= 1'b0;
`endif
        end else begin
            if (in_ready) v1_q <= in_valid;
            if (in_valid && in_ready) begin
                p_q    <= p_d;
                g_q    <= g_d;
                cin_q  <= cin_d;
                grp_q  <= grp_d;
`ifdef CLA_SATURATE_EN
                sat_q  <= sat;
                amsb_q <= a[WIDTH-1];
`endif
            end
            if (s2_load) v2_q <= v1_q;
            if (s2_load && v1_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench driving 8-, 32- and 64-bit adders in lockstep.
module tb_pipelined_cla_adder;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        logic        sat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, c_in, sub, sat;
    logic [63:0] a64, b64;
    logic        in_ready, out_valid, c32, o32, z32;
    logic [31:0] sum32;
    logic        ir8, ov8, c8, o8, z8;
    logic [7:0]  sum8;
    logic        ir64, ov64, c64, o64, z64;
    logic [63:0] sum64;

    beat_t       sb[$];
    beat_t       mon_e;
    int          tests = 0;
    int          fails = 0;
    int          out_cnt = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a64[31:0]), .b(b64[31:0]), .c_in(c_in), .sub(sub),
`ifdef CLA_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum32), .c_out(c32), .overflow(o32), .zero(z32)
    );

    pipelined_cla_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .a(a64[7:0]), .b(b64[7:0]), .c_in(c_in), .sub(sub),
`ifdef CLA_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(ov8), .out_ready(out_ready),
        .sum(sum8), .c_out(c8), .overflow(o8), .zero(z8)
    );

    pipelined_cla_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64),
        .a(a64), .b(b64), .c_in(c_in), .sub(sub),
`ifdef CLA_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(ov64), .out_ready(out_ready),
        .sum(sum64), .c_out(c64), .overflow(o64), .zero(z64)
    );

    // Behavioural reference: {zero, overflow, carry, sum} for a w-bit adder.
    function automatic logic [66:0] model(input beat_t e, input int w);
        logic [63:0] m, ae, be, s;
        logic [64:0] full;
        logic        co, ov;
        m    = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        ae   = e.a & m;
        be   = (e.sub ? ~e.b : e.b) & m;
        full = {1'b0, ae} + {1'b0, be} + {64'd0, e.sub | e.cin};
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (ae[w-1] == be[w-1]) && (s[w-1] != ae[w-1]);
        if (e.sat && ov) s = ae[w-1] ? (64'd1 << (w-1)) : (m >> 1);
        return {s == 64'd0, ov, co, s};
    endfunction

    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got output sum=%h, required no output", sum32);
                end else begin
                    mon_e = sb.pop_front();
                    out_cnt++;
                    tests++;
                    if ({z32, o32, c32, 32'd0, sum32} !== model(mon_e, 32)) begin
                        fails++;
                        $display("FAIL sb_w32: got %h, required %h", {z32, o32, c32, 32'd0, sum32}, model(mon_e, 32));
                    end
                    tests++;
                    if ({ov8, z8, o8, c8, 56'd0, sum8} !== {1'b1, model(mon_e, 8)}) begin
                        fails++;
                        $display("FAIL sb_w8: got %h, required %h", {ov8, z8, o8, c8, 56'd0, sum8}, {1'b1, model(mon_e, 8)});
                    end
                    tests++;
                    if ({ov64, z64, o64, c64, sum64} !== {1'b1, model(mon_e, 64)}) begin
                        fails++;
                        $display("FAIL sb_w64: got %h, required %h", {ov64, z64, o64, c64, sum64}, {1'b1, model(mon_e, 64)});
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back('{a64, b64, sub, c_in, sat});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] ta, input logic [63:0] tb, input logic ts, input logic tc, input logic tsat);
        a64 = ta;
        b64 = tb;
        sub = ts;
        c_in = tc;
        sat = tsat;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b, required 0", out_valid);
        end
        tests++;
        if ({sum32, c32, o32, z32} !== 35'd0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0", {sum32, c32, o32, z32});
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b, required 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_carry_wrap();
        out_ready = 1'b1;
        beat(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: got out_valid=%b, required 0", out_valid);
        end
        step();
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency: got out_valid=%b, required 1", out_valid);
        end
        tests++;
        if ({sum32, c32, z32, o32} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL carry_wrap: got sum=%h c=%b z=%b v=%b, required 0 1 1 0", sum32, c32, z32, o32);
        end
    endtask

    task automatic test_overflow();
        beat(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        step();
        tests++;
        if ({sum32, o32, c32, z32} !== {32'h8000_0000, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL overflow: got sum=%h v=%b c=%b z=%b, required 80000000 1 0 0", sum32, o32, c32, z32);
        end
`ifdef CLA_SATURATE_EN
        beat(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
        sat = 1'b0;
        step();
        tests++;
        if ({sum32, o32} !== {32'h7FFF_FFFF, 1'b1}) begin
            fails++;
            $display("FAIL saturate: got sum=%h v=%b, required 7fffffff 1", sum32, o32);
        end
`endif
    endtask

    task automatic test_subtract();
        beat(64'd5, 64'd7, 1'b1, 1'b1, 1'b0);
        beat(64'd7, 64'd5, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({sum32, c32, o32, z32} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sub_neg: got sum=%h c=%b v=%b z=%b, required fffffffe 0 0 0", sum32, c32, o32, z32);
        end
        step();
        tests++;
        if ({sum32, c32, o32, z32} !== {32'd2, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sub_pos: got sum=%h c=%b v=%b z=%b, required 2 1 0 0", sum32, c32, o32, z32);
        end
    endtask

    task automatic test_back_to_back();
        int cnt0;
        step();
        step();
        cnt0 = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a64 = {$urandom(), $urandom()};
            b64 = {$urandom(), $urandom()};
            sub = 1'($urandom_range(0, 1));
            c_in = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready: beat %0d got in_ready=%b, required 1", i, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        tests++;
        if (out_cnt - cnt0 !== 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d results, required 8", out_cnt - cnt0);
        end
    endtask

    task automatic test_backpressure();
        int          cnt0, n;
        beat_t       e0;
        logic [31:0] held;
        logic [66:0] ex;
        step();
        step();
        cnt0 = out_cnt;
        n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            a64 = 64'h0123_4567_89AB_CDEF * 64'(n + 1);
            b64 = 64'hFEDC_BA98_7654_3210 + 64'(n);
            sub = n[0];
            c_in = 1'b1;
            in_valid = 1'b1;
            if (n == 0) e0 = '{a64, b64, sub, c_in, sat};
            #1;
            if (in_ready) n++;
            step();
        end
        tests++;
        if (n !== 2) begin
            fails++;
            $display("FAIL bp_accepted: got %0d beats, required 2", n);
        end
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        held = sum32;
        ex = model(e0, 32);
        tests++;
        if (held !== ex[31:0]) begin
            fails++;
            $display("FAIL bp_first: got %h, required %h", held, ex[31:0]);
        end
        step();
        step();
        tests++;
        if (sum32 !== held || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: got sum=%h valid=%b, required %h 1", sum32, out_valid, held);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            a64 = 64'h0123_4567_89AB_CDEF * 64'(n + 1);
            b64 = 64'hFEDC_BA98_7654_3210 + 64'(n);
            sub = n[0];
            in_valid = 1'b1;
            #1;
            if (in_ready) n++;
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && out_cnt - cnt0 < 4; c++) step();
        step();
        step();
        tests++;
        if (out_cnt - cnt0 !== 4 || n !== 4) begin
            fails++;
            $display("FAIL bp_drain: got %0d results of %0d beats, required 4 of 4", out_cnt - cnt0, n);
        end
    endtask

    task automatic test_reset_mid();
        int cnt0;
        step();
        step();
        out_ready = 1'b0;
        beat(64'h1111, 64'h2222, 1'b0, 1'b0, 1'b0);
        beat(64'h3333, 64'h4444, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        cnt0 = out_cnt;
        out_ready = 1'b1;
        repeat (4) step();
        tests++;
        if (out_cnt !== cnt0 || sb.size() != 0) begin
            fails++;
            $display("FAIL rst_discard: got %0d outputs, %0d pending, required 0 0", out_cnt - cnt0, sb.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a64 = ($urandom_range(0, 7) == 0) ? '1 : {$urandom(), $urandom()};
            b64 = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom(), $urandom()};
            sub = 1'($urandom_range(0, 1));
            c_in = 1'($urandom_range(0, 1));
`ifdef CLA_SATURATE_EN
            sat = 1'($urandom_range(0, 1));
`endif
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat = 1'b0;
        for (int c = 0; c < 50 && sb.size() != 0; c++) step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL rand_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a64 = '0;
        b64 = '0;
        sub = 1'b0;
        c_in = 1'b0;
        sat = 1'b0;
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the RISC datapath ALU and address-generation paths.
- Generalises the 4-bit lookahead carry logic to WIDTH bits, using 4-bit groups plus a second-level group-carry lookahead.
- Two register stages with a valid/ready handshake, so the adder can be stalled by downstream units.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of 4 and within 4..64.
- GROUP_W, 4: bits per lookahead group. Fixed at 4; any other value is rejected at elaboration.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder can accept an operand beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in. Ignored when sub=1.
- sub  in  1  1 = compute a - b.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB. When sub=1 it means no-borrow.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high: clk and rst as above, sampled on the rising edge of clk.
- Reset values: all stage valid bits are 0, so out_valid=0. sum, c_out, overflow and zero reset to 0. in_ready=1 in the cycle after reset.
- Operand preparation, combinational before stage 1:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
  - Per-bit p = a ^ b_eff, g = a & b_eff.
- Stage 1 register (S1): captures p, g and cin_eff. Also captures each group's propagate and generate:
  - PG = &p[group].
  - GG = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Stage 2 register (S2):
  - Group carries come from a second-level lookahead over (PG, GG, cin_eff), using the same 4-input form recursively across groups of groups.
  - In-group carries come from the cla_group4 sub-module.
  - sum = p ^ carries.
  - c_out = carry out of the top group.
  - overflow = carry into MSB ^ carry out of MSB.
  - zero = ~|sum.
  - S2 holds sum and all flags.
- Latency: a beat accepted in cycle N appears on out_valid at N+2 when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake, elastic pipeline:
  - A stage loads when it is empty or its content is advancing.
  - S2 advances when out_ready=1 or S2 is empty.
  - S1 advances when S2 loads.
  - in_ready = ~S1_valid | S2_load. This is combinational from out_ready, with no path to in_valid.
  - A beat transfers on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Stall: while out_valid=1 and out_ready=0, sum and all flags hold stable. Up to 2 beats can be in flight; a third is refused (in_ready=0).
- Bubbles: an empty S1 collapses. If S2 is full and stalled while S1 is empty, in_ready stays 1 and one beat is accepted into S1.
- Simultaneous output transfer and input accept: the pipeline shifts with no lost beat and no duplicate.
- Reset mid-operation: in-flight beats are discarded and out_valid=0 on the next cycle regardless of out_ready.
- Arithmetic: modular WIDTH-bit wrap. c_in is ignored in subtract mode; there is no subtract-with-borrow.
- The output must be independent of X on a or b while in_valid=0. Registers load data only on an accepted beat.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- When defined, the extra input port sat (1 bit, registered into S1 with the beat) exists. With sat=1 and overflow=1, sum is clamped to 0x7F..F on positive overflow, or to 0x80..0 on negative overflow. The positive/negative case is taken from the MSB of a.
  - overflow still reports the raw condition.
  - zero is computed on the clamped sum.
  - Latency is unchanged.
- When undefined, the sat port is absent and sum is always the raw wrapped result.

Decomposition:
- Shared package cla_pkg holds:
  - the constant CLA_GROUP_W = 4;
  - the function num_groups(width);
  - the typedef cla_pg_t, a struct {p, g}, used by the ALU and the branch-compare unit.
- Sub-module cla_group4: 4-bit combinational group.
  - Inputs: p[3:0], g[3:0], ci.
  - Outputs: carries[3:0], group P, group G.
  - It is instantiated WIDTH/4 times in stage 2. The group P/G logic is shared with stage 1.

Test Plan:
- Carry wrap: a=0xFFFFFFFF, b=0x00000001, sub=0, c_in=0 -> two cycles later: sum=0x00000000, c_out=1, zero=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1, c_out=0. With CLA_SATURATE_EN and sat=1 -> sum=0x7FFFFFFF.
- Subtract:
  - a=5, b=7, sub=1, c_in=1 -> sum=0xFFFFFFFE, c_out=0, overflow=0. This also shows c_in is ignored.
  - a=7, b=5 -> sum=2, c_out=1.
- Backpressure: stream 4 back-to-back beats with out_ready held low from cycle 2 -> in_ready drops after 2 accepted beats and sum holds steady. Release out_ready -> all 4 results emerge in order with no loss or duplication.
- Reset mid-stream: 2 beats in flight, assert rst for 1 cycle -> out_valid=0 next cycle and in_ready=1. The discarded beats never appear.
- Random regression over WIDTH in {8, 32, 64} and random stall patterns: a scoreboard checks sum, c_out and overflow against a behavioural a + b_eff + cin_eff reference.
